// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target and its bus front end.
//   state_t   : target FSM states
//   I2C_READ  : R/W bit value for a read transfer
//   I2C_WRITE : R/W bit value for a write transfer
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/i2c_target_if.sv
// Bus and byte-handshake signals of the I2C target.
//   scl, sda_i : bus levels seen by the target
//   sda_oe     : 1 = target pulls SDA low
//   rx_data/rx_valid : received write byte and its one-cycle strobe
//   tx_data/tx_req   : read byte and its one-cycle fetch request
//   rw, busy   : R/W of the matched transaction, transaction-active flag
// slave  : the target's view
// master : the surrounding system / bus side
interface i2c_target_if;

    logic       scl;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       rw;
    logic       busy;

    modport slave (
        input  scl, sda_i, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, rw, busy
    );

    modport master (
        output scl, sda_i, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, rw, busy
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser and bus-event detector.
//   clk, reset   : system clock, synchronous active-high reset
//   scl, sda_i   : asynchronous bus levels
//   sda_s        : synchronised SDA level
//   scl_rise/scl_fall : single-cycle SCL edge strobes
//   start/stop   : single-cycle START / STOP condition strobes
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Idle bus is high on both lines; resetting to 1 avoids a false edge
    // or START when reset is released on a quiet bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    // SCL must be high in both samples so an SCL edge never looks like START/STOP.
    assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// 7-bit-address I2C target.
//   clk, reset : system clock (>= 8x SCL), synchronous active-high reset
//   bus        : i2c_target_if.slave -- SCL/SDA, rx byte + strobe,
//                tx byte + request strobe, rw and busy status
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'b1110000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           reset,
    i2c_target_if.slave   bus
);

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk      (clk),
        .reset    (reset),
        .scl      (bus.scl),
        .sda_i    (bus.sda_i),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       load_q, load_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_byte_d  = tx_byte_q;
        load_d     = 1'b0;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        rw_d       = rw_q;
        busy_d     = busy_q;

        if (stop) begin
            state_d  = IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start) begin
            state_d  = ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;

                ADDR: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        if (shift_q[7:1] == DEV_ADDR) begin
                            sda_oe_d = 1'b1;
                            rw_d     = shift_q[0];
                            busy_d   = 1'b1;
                            state_d  = ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = IGNORE;
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q == I2C_WRITE) begin
                            sda_oe_d = 1'b0;
                            state_d  = WR_DATA;
                        end else begin
                            // ACK stays driven until the fetched byte's MSB
                            // replaces it on the load cycle.
                            state_d  = RD_DATA;
                            tx_req_d = 1'b1;
                            load_d   = 1'b1;
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d    = '0;
                        sda_oe_d = 1'b1;
                        state_d  = WR_ACK;
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        cnt_d    = '0;
                        sda_oe_d = 1'b0;
                        state_d  = WR_DATA;
                    end
                end

                RD_DATA: begin
                    // load_q marks the cycle after tx_req: capture the byte
                    // and present its MSB while SCL is still low.
                    if (load_q) begin
                        tx_byte_d = bus.tx_data;
                        sda_oe_d  = ~bus.tx_data[7];
                    end else if (scl_rise && cnt_q != 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d    = '0;
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK;
                        end else begin
                            sda_oe_d = ~tx_byte_q[3'd7 - cnt_q[2:0]];
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        sda_oe_d = 1'b0;
                        state_d  = IGNORE;
                    end else if (scl_fall) begin
                        cnt_d    = '0;
                        tx_req_d = 1'b1;
                        load_d   = 1'b1;
                        state_d  = RD_DATA;
                    end
                end

                IGNORE: sda_oe_d = 1'b0;

                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_byte_q  <= '0;
            load_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_byte_q  <= tx_byte_d;
            load_q     <= load_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.rw       = rw_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed testbench for i2c_target: acts as the I2C initiator on an
// open-drain SDA line and as the byte source for read transfers.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic reset;
    logic sda_m;           // initiator's drive: 0 = pull low, 1 = release

    int total = 0;
    int bad   = 0;

    int         rx_cnt  = 0;
    int         txr_cnt = 0;
    int         oe_cnt  = 0;
    int         bsy_cnt = 0;
    logic [7:0] last_rx = 8'h00;
    int         tx_idx  = 0;
    logic [7:0] tx_list [4] = '{8'h3C, 8'hC3, 8'h5A, 8'h00};

    always #5 clk = ~clk;

    i2c_target_if bus ();

    i2c_target #(
        .DEV_ADDR    (7'h70),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Wired-AND of initiator and target on SDA.
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    // Activity monitor and tx byte source (new byte ready the cycle after tx_req).
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_cnt  <= rx_cnt + 1;
            last_rx <= bus.rx_data;
        end
        if (bus.tx_req) begin
            txr_cnt     <= txr_cnt + 1;
            bus.tx_data <= (tx_idx < 4) ? tx_list[tx_idx] : 8'hFF;
            tx_idx      <= tx_idx + 1;
        end
        if (bus.sda_oe) oe_cnt  <= oe_cnt + 1;
        if (bus.busy)   bsy_cnt <= bsy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic b, output logic line);
        wq(); sda_m = b;
        wq(); bus.scl = 1'b1;
        wq(); line = sda_m & ~bus.sda_oe;
        wq(); bus.scl = 1'b0;
    endtask

    task automatic i2c_start();
        wq(); sda_m = 1'b0;
        wq(); bus.scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        wq(); sda_m = 1'b1;
        wq(); bus.scl = 1'b1;
        wq(); sda_m = 1'b0;
        wq(); bus.scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wq(); sda_m = 1'b0;
        wq(); bus.scl = 1'b1;
        wq(); sda_m = 1'b1;
        wq();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], l);
        bit_cycle(1'b1, ack);
    endtask

    task automatic read_byte(input logic ackb, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, l);
            d[i] = l;
        end
        bit_cycle(ackb, l);
    endtask

    logic       ack;
    logic [7:0] d;
    int         rx0, txr0, oe0, bsy0;

    initial begin
        reset   = 1'b1;
        bus.scl = 1'b1;
        sda_m   = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state
        chk("rst_sda_oe",   bus.sda_oe,   0);
        chk("rst_rx_data",  bus.rx_data,  0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_tx_req",   bus.tx_req,   0);
        chk("rst_rw",       bus.rw,       0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_state",    dut.state_q,  IDLE);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Write to own address: 0xE0, 0xA5
        rx0 = rx_cnt;
        i2c_start();
        send_byte(8'hE0, ack);
        chk("wr_addr_ack", ack, 0);
        chk("wr_busy",     bus.busy, 1);
        chk("wr_rw",       bus.rw, I2C_WRITE);
        send_byte(8'hA5, ack);
        chk("wr_data_ack", ack, 0);
        chk("wr_rx_cnt",   rx_cnt - rx0, 1);
        chk("wr_rx_data",  last_rx, 8'hA5);
        chk("wr_busy_pre_stop", bus.busy, 1);
        i2c_stop();
        chk("wr_busy_stop", bus.busy, 0);

        // Address mismatch: 0x42+W, 0x11
        rx0 = rx_cnt; oe0 = oe_cnt; bsy0 = bsy_cnt;
        i2c_start();
        send_byte(8'h84, ack);
        chk("mm_addr_nack", ack, 1);
        send_byte(8'h11, ack);
        chk("mm_data_nack", ack, 1);
        i2c_stop();
        chk("mm_oe_cycles",   oe_cnt - oe0, 0);
        chk("mm_rx_cnt",      rx_cnt - rx0, 0);
        chk("mm_busy_cycles", bsy_cnt - bsy0, 0);

        // Read two bytes: 0x3C (ACK), 0xC3 (NACK)
        txr0 = txr_cnt;
        i2c_start();
        send_byte(8'hE1, ack);
        chk("rd_addr_ack", ack, 0);
        chk("rd_rw",       bus.rw, I2C_READ);
        read_byte(1'b0, d);
        chk("rd_byte0", d, 8'h3C);
        read_byte(1'b1, d);
        chk("rd_byte1", d, 8'hC3);
        chk("rd_tx_req_cnt", txr_cnt - txr0, 2);
        chk("rd_released",   bus.sda_oe, 0);
        chk("rd_ignore",     dut.state_q, IGNORE);
        i2c_stop();
        chk("rd_busy_stop", bus.busy, 0);

        // Repeated START: write 0x01, then read one byte with NACK
        rx0 = rx_cnt; txr0 = txr_cnt;
        i2c_start();
        send_byte(8'hE0, ack);
        chk("rs_wr_ack", ack, 0);
        chk("rs_rw_wr",  bus.rw, I2C_WRITE);
        send_byte(8'h01, ack);
        chk("rs_data_ack", ack, 0);
        i2c_rstart();
        chk("rs_busy_after_rstart", bus.busy, 0);
        chk("rs_rw_held", bus.rw, I2C_WRITE);
        send_byte(8'hE1, ack);
        chk("rs_rd_ack", ack, 0);
        chk("rs_rw_rd",  bus.rw, I2C_READ);
        read_byte(1'b1, d);
        chk("rs_rd_byte", d, 8'h5A);
        i2c_stop();
        chk("rs_rx_cnt",  rx_cnt - rx0, 1);
        chk("rs_rx_data", bus.rx_data, 8'h01);
        chk("rs_tx_req_cnt", txr_cnt - txr0, 1);

        // Reset while target drives a 0 bit of 0x00
        i2c_start();
        send_byte(8'hE1, ack);
        chk("rr_addr_ack", ack, 0);
        wq(); sda_m = 1'b1;
        wq(); bus.scl = 1'b1;
        wq();
        chk("rr_driving", bus.sda_oe, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rr_sda_oe",   bus.sda_oe,   0);
        chk("rr_rx_data",  bus.rx_data,  0);
        chk("rr_rx_valid", bus.rx_valid, 0);
        chk("rr_tx_req",   bus.tx_req,   0);
        chk("rr_rw",       bus.rw,       0);
        chk("rr_busy",     bus.busy,     0);
        chk("rr_state",    dut.state_q,  IDLE);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        i2c_start();
        send_byte(8'hE0, ack);
        chk("rr_after_ack",  ack, 0);
        chk("rr_after_busy", bus.busy, 1);
        i2c_stop();

        // STOP after 4 data bits of a write
        rx0 = rx_cnt;
        i2c_start();
        send_byte(8'hE0, ack);
        chk("sm_addr_ack", ack, 0);
        bit_cycle(1'b1, ack);
        bit_cycle(1'b0, ack);
        bit_cycle(1'b1, ack);
        bit_cycle(1'b1, ack);
        i2c_stop();
        chk("sm_rx_cnt", rx_cnt - rx0, 0);
        chk("sm_state",  dut.state_q, IDLE);
        chk("sm_busy",   bus.busy, 0);
        chk("sm_sda_oe", bus.sda_oe, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- 7-bit-address I2C target (responder). It answers transactions from the I2C initiator block on the same SCL/SDA pair.
- Oversamples SCL and SDA on the system clock, detects START/STOP, and matches its own address.
- Write transfers: received bytes are presented on a byte-wide output with a one-cycle valid strobe.
- Read transfers: bytes are serialised from a byte-wide input, fetched with a one-cycle request strobe.

Parameters:
- DEV_ADDR, 7'b1110000, target's own 7-bit address.
- SYNC_STAGES, 2, flip-flop stages on the scl/sda_i synchronisers (minimum 2).

Ports:
- clk  input  1  system clock; frequency at least 8x SCL.
- reset  input  1  synchronous reset, active-high.
- scl  input  1  I2C clock from the bus (target never stretches).
- sda_i  input  1  sampled SDA bus level.
- sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain, external pad).
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-cycle pulse; rx_data is valid this cycle.
- tx_data  input  8  byte to send in a read transfer; sampled one cycle after tx_req.
- tx_req  output  1  one-cycle pulse requesting the next tx_data byte.
- rw  output  1  R/W bit of the current matched transaction (1 = read).
- busy  output  1  high from address match until STOP or a new START.

Behaviour:
- Reset values: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, rw=0, busy=0; FSM=IDLE, bit counter=0. Reset mid-transfer releases SDA in the same cycle the reset is registered.
- Synchronise scl and sda_i through SYNC_STAGES flops, then keep one previous-sample register each.
- Edge definitions, all on synchronised signals:
  - scl_rise / scl_fall: transitions of SCL.
  - START: SDA 1->0 while SCL=1.
  - STOP: SDA 0->1 while SCL=1.
- Priority, highest first: reset > STOP > START > SCL edges.
  - START in any state (including repeated START) -> ADDR, bit counter=0, sda_oe=0.
  - STOP in any state -> IDLE, sda_oe=0, busy=0.
- Bits are sampled on scl_rise. sda_oe changes only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7 address + R/W). On the 8th scl_fall:
    - match -> drive sda_oe=1, latch rw, busy=1, go to ADDR_ACK;
    - mismatch -> sda_oe=0, go to IGNORE.
  - ADDR_ACK: hold ACK low through the 9th SCL high. On the 9th scl_fall:
    - rw=0 -> release, go to WR_DATA;
    - rw=1 -> go to RD_DATA and drive sda_oe = ~tx_byte[7].
  - WR_DATA: shift 8 bits. On the 8th scl_rise, register rx_data and pulse rx_valid for one clk. On the 8th scl_fall, sda_oe=1 and go to WR_ACK.
  - WR_ACK: on scl_fall, release and return to WR_DATA with counter=0. Every write byte is ACKed.
  - RD_DATA:
    - tx_req pulses on the cycle of the scl_fall that enters RD_DATA; tx_data is registered into tx_byte on the following cycle.
    - That first bit is set one cycle later than the scl_fall; SDA still settles before SCL rises because clk >= 8x SCL.
    - On each later scl_fall, drive sda_oe = ~tx_byte[7-n].
    - On the 8th scl_fall, release and go to RD_ACK.
  - RD_ACK: sample the initiator's bit on scl_rise.
    - 0 (ACK) -> on scl_fall, re-enter RD_DATA (new tx_req, next byte).
    - 1 (NACK) -> go to IGNORE with SDA released.
  - IGNORE: SDA released; leave only on START or STOP.
- Bit counter is 4 bits and resets to 0 on every byte-state entry; no wrap beyond 8.
- An SDA transition while SCL is high caused by our own drive cannot occur, because sda_oe changes only after scl_fall.
- Unlimited bytes per transaction; no internal buffering beyond one byte.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - constants I2C_READ=1, I2C_WRITE=0.
- One natural sub-module, i2c_bus_sync: synchroniser plus edge/START/STOP detector, outputs scl_rise, scl_fall, start, stop, sda_s. It is reusable by the initiator.

Test Plan:
- Write, matching address: START, 0xE0 (0x70+W), data 0xA5, STOP -> ACK low on 9th clocks of both bytes; rx_valid pulses once with rx_data=0xA5; busy 1->0 at STOP.
- Address mismatch: START, 0x42+W, 0x11, STOP -> sda_oe never asserted; rx_valid never pulses; busy stays 0.
- Read, two bytes: START, 0xE1; tx_data=0x3C then 0xC3; initiator ACK then NACK -> SDA carries 00111100 then 11000011; exactly two tx_req pulses; released after NACK.
- Repeated START: write 0xE0, 0x01, then START 0xE1, read 1 byte NACK, STOP -> rx_data=0x01; rw goes 0->1 at second address ACK; one tx_req.
- Reset mid-read: assert reset while driving a 0 bit of 0x00 -> sda_oe=0 next clk; all outputs at reset values; next START+0xE0 is ACKed normally.
- STOP mid-byte: STOP after 4 data bits of a write -> no rx_valid; FSM IDLE; busy=0.
